// File: rtl/hram_bridge_pkg.sv
// Shared definitions for the UART-to-HyperRAM burst bridge.
// Holds command codes, the FSM state encoding and the status word bit positions.
// Also holds the controller configuration values applied at reset.
package hram_bridge_pkg;

  localparam logic [7:0] CMD_ADDR     = 8'h01;
  localparam logic [7:0] CMD_LOAD     = 8'h02;
  localparam logic [7:0] CMD_WRITE    = 8'h03;
  localparam logic [7:0] CMD_READ     = 8'h04;
  localparam logic [7:0] CMD_READ_REQ = 8'h05;
  localparam logic [7:0] CMD_STATUS   = 8'h08;
  localparam logic [7:0] CMD_CONFIG   = 8'h09;

  typedef enum logic [3:0] {
    IDLE, EXEC, WR_WAIT, WR_ISSUE, RD_WAIT, RD_COLLECT,
    REPLY_LOAD, REPLY_START, REPLY_WAITLO, REPLY_WAITHI
  } state_t;

  // Sticky flag positions in the STATUS reply word
  localparam int ST_OVR = 16;
  localparam int ST_UNF = 17;
  localparam int ST_TO  = 18;

  localparam logic [7:0] LAT1X_RST = 8'h10;
  localparam logic [7:0] LAT2X_RST = 8'd21;

endpackage

// File: rtl/hram_word_fifo.sv
// Synchronous word FIFO with first-word fall-through output and occupancy count.
// Latency: a push is visible at dout the cycle after it is written into an empty FIFO.
// Backpressure: a push when full and a pop when empty are ignored.
module hram_word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                   hram_clk,
  input  logic                   rstn,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy tracking; depth is a power of two so pointers wrap naturally
  always_ff @(posedge hram_clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array write port
  always_ff @(posedge hram_clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/hram_uart_burst_bridge.sv
// Decodes UART command frames into HyperRAM controller bursts and returns one reply word per command.
// Latency: command executes the cycle after its last frame byte; each reply byte waits for a uart_tx idle/busy/idle cycle.
// Backpressure: bytes arriving outside IDLE are dropped (OVR); controller requests wait for hr_busy low.
module hram_uart_burst_bridge
  import hram_bridge_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int BURST_MAX   = 16,
  parameter int TIMEOUT_CYC = 500000
) (
  input  logic                hram_clk,
  input  logic                rstn,
  input  logic                rx_rcv,
  input  logic [7:0]          rx_data,
  output logic                tx_start,
  output logic [7:0]          tx_data,
  input  logic                tx_ready,
  output logic                hr_rd_req,
  output logic                hr_wr_req,
  output logic [ADDR_W-1:0]   hr_addr,
  output logic [DATA_W-1:0]   hr_wr_d,
  output logic [DATA_W/8-1:0] hr_wr_byte_en,
  output logic [21:0]         hr_rd_num_dwords,
  input  logic [DATA_W-1:0]   hr_rd_d,
  input  logic                hr_rd_rdy,
  input  logic                hr_busy,
  output logic [7:0]          latency_1x,
  output logic [7:0]          latency_2x,
  output logic                mem_or_reg
);
  localparam int NB  = DATA_W / 8;
  localparam int BCW = $clog2(NB + 1);
  localparam int TCW = $clog2(TIMEOUT_CYC + 1);
  localparam int CW  = $clog2(BURST_MAX) + 1;
  localparam logic [DATA_W-1:0] ERR = '1;

  state_t            state, state_nxt;
  logic [BCW-1:0]    byte_cnt, tx_cnt;
  logic [TCW-1:0]    to_cnt;
  logic [7:0]        cmd;
  logic [DATA_W-1:0] data, rply, rply_val, tx_word, status_w;
  logic [21:0]       rd_n, rd_cnt;
  logic [CW-1:0]     wr_cnt, wf_count, rf_count;
  logic              to_f, unf_f, ovr_f;
  logic              frame_done, to_hit, rd_ok;
  logic              wf_push, wf_pop, wf_full, wf_empty;
  logic              rf_push, rf_pop, rf_full, rf_empty;
  logic [DATA_W-1:0] wf_dout, rf_dout;
  logic              rply_ld, addr_ld, cfg_ld, set_unf, clr_flags;
  logic              wr_fire, rd_fire, rd_done, burst_init, tx_fire, tx_shift;

  assign hr_wr_byte_en = '1;
  assign frame_done = (state == IDLE) && rx_rcv && (byte_cnt == BCW'(NB));
  assign to_hit     = (byte_cnt != '0) && !rx_rcv && (to_cnt == TCW'(TIMEOUT_CYC));
  assign rd_ok      = (data[21:0] != '0) &&
                      (data[21:0] <= 22'(BURST_MAX) - 22'(rf_count));

  hram_word_fifo #(.WIDTH(DATA_W), .DEPTH(BURST_MAX)) u_wfifo (
    .hram_clk(hram_clk), .rstn(rstn), .push(wf_push), .pop(wf_pop), .din(data),
    .dout(wf_dout), .full(wf_full), .empty(wf_empty), .count(wf_count));

  hram_word_fifo #(.WIDTH(DATA_W), .DEPTH(BURST_MAX)) u_rfifo (
    .hram_clk(hram_clk), .rstn(rstn), .push(rf_push), .pop(rf_pop), .din(hr_rd_d),
    .dout(rf_dout), .full(rf_full), .empty(rf_empty), .count(rf_count));

  // Status word: FIFO levels in the low bytes, sticky flags above them
  always_comb begin
    status_w         = '0;
    status_w[7:0]    = 8'(wf_count);
    status_w[15:8]   = 8'(rf_count);
    status_w[ST_OVR] = ovr_f;
    status_w[ST_UNF] = unf_f;
    status_w[ST_TO]  = to_f;
  end

  // State register
  always_ff @(posedge hram_clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode and per-cycle control strobes
  always_comb begin
    state_nxt = state;
    wf_push = 1'b0; wf_pop = 1'b0; rf_push = 1'b0; rf_pop = 1'b0;
    rply_ld = 1'b0; rply_val = ERR;
    addr_ld = 1'b0; cfg_ld = 1'b0; set_unf = 1'b0; clr_flags = 1'b0;
    wr_fire = 1'b0; rd_fire = 1'b0; rd_done = 1'b0; burst_init = 1'b0;
    tx_fire = 1'b0; tx_shift = 1'b0;
    case (state)
      IDLE: if (frame_done) state_nxt = EXEC;
      EXEC: begin
        state_nxt = REPLY_LOAD;
        rply_ld   = 1'b1;
        case (cmd)
          CMD_ADDR:   begin addr_ld = 1'b1; rply_val = data; end
          CMD_LOAD:   if (!wf_full) begin wf_push = 1'b1; rply_val = data; end
          CMD_WRITE:  if (!wf_empty) begin rply_ld = 1'b0; burst_init = 1'b1; state_nxt = WR_WAIT; end
          CMD_READ:   if (!rf_empty) begin rf_pop = 1'b1; rply_val = rf_dout; end
                      else set_unf = 1'b1;
          CMD_READ_REQ: if (rd_ok) begin rply_ld = 1'b0; burst_init = 1'b1; state_nxt = RD_WAIT; end
          CMD_STATUS: begin rply_val = status_w; clr_flags = 1'b1; end
          CMD_CONFIG: begin cfg_ld = 1'b1; rply_val = data; end
          default: ;
        endcase
      end
      // The cycle carrying hr_wr_req is skipped: the controller's busy is not yet visible
      WR_WAIT: if (!hr_wr_req) begin
        if (wf_empty) begin
          rply_ld = 1'b1; rply_val = DATA_W'(wr_cnt); state_nxt = REPLY_LOAD;
        end else if (!hr_busy) begin
          state_nxt = WR_ISSUE;
        end
      end
      WR_ISSUE: begin wf_pop = 1'b1; wr_fire = 1'b1; state_nxt = WR_WAIT; end
      RD_WAIT:  if (!hr_busy) begin rd_fire = 1'b1; state_nxt = RD_COLLECT; end
      RD_COLLECT: if (hr_rd_rdy && !rf_full) begin
        rf_push = 1'b1;
        if (rd_cnt + 22'd1 == rd_n) begin
          rd_done = 1'b1; rply_ld = 1'b1; rply_val = DATA_W'(rd_n); state_nxt = REPLY_LOAD;
        end
      end
      REPLY_LOAD:   state_nxt = REPLY_START;
      REPLY_START:  if (tx_ready) begin tx_fire = 1'b1; state_nxt = REPLY_WAITLO; end
      REPLY_WAITLO: if (!tx_ready) state_nxt = REPLY_WAITHI;
      REPLY_WAITHI: if (tx_ready) begin
        tx_shift  = 1'b1;
        state_nxt = (tx_cnt == BCW'(NB - 1)) ? IDLE : REPLY_START;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Frame assembly and inter-byte timeout
  always_ff @(posedge hram_clk or negedge rstn) begin
    if (!rstn) begin
      byte_cnt <= '0; to_cnt <= '0; cmd <= '0; data <= '0;
    end else begin
      if ((state == IDLE) && rx_rcv) begin
        if (byte_cnt == '0) cmd <= rx_data;
        else                data <= {data[DATA_W-9:0], rx_data};
        byte_cnt <= (byte_cnt == BCW'(NB)) ? '0 : byte_cnt + BCW'(1);
      end else if (to_hit) begin
        byte_cnt <= '0;
      end
      if (rx_rcv || byte_cnt == '0)           to_cnt <= '0;
      else if (to_cnt != TCW'(TIMEOUT_CYC))   to_cnt <= to_cnt + TCW'(1);
    end
  end

  // Sticky flags; a new event wins over a clear in the same cycle
  always_ff @(posedge hram_clk or negedge rstn) begin
    if (!rstn) begin
      to_f <= 1'b0; unf_f <= 1'b0; ovr_f <= 1'b0;
    end else begin
      to_f  <= (to_f  & ~clr_flags) | to_hit;
      unf_f <= (unf_f & ~clr_flags) | set_unf;
      ovr_f <= (ovr_f & ~clr_flags) | (rx_rcv && (state != IDLE));
    end
  end

  // Controller interface, burst counters, configuration and reply shifter
  always_ff @(posedge hram_clk or negedge rstn) begin
    if (!rstn) begin
      hr_wr_req <= 1'b0; hr_rd_req <= 1'b0; tx_start <= 1'b0; tx_data <= '0;
      hr_addr <= '0; hr_wr_d <= '0; hr_rd_num_dwords <= 22'd1;
      latency_1x <= LAT1X_RST; latency_2x <= LAT2X_RST; mem_or_reg <= 1'b0;
      rply <= '0; tx_word <= '0; tx_cnt <= '0;
      wr_cnt <= '0; rd_cnt <= '0; rd_n <= '0;
    end else begin
      hr_wr_req <= wr_fire;
      hr_rd_req <= rd_fire;
      tx_start  <= tx_fire;
      if (rply_ld) rply <= rply_val;
      if (addr_ld)        hr_addr <= ADDR_W'(data);
      else if (hr_wr_req) hr_addr <= hr_addr + ADDR_W'(1);
      else if (rd_done)   hr_addr <= hr_addr + ADDR_W'(rd_n);
      if (wr_fire) begin hr_wr_d <= wf_dout; wr_cnt <= wr_cnt + CW'(1); end
      if (rd_fire) hr_rd_num_dwords <= rd_n;
      if (burst_init) begin wr_cnt <= '0; rd_cnt <= '0; rd_n <= data[21:0]; end
      if (rf_push) rd_cnt <= rd_cnt + 22'd1;
      if (cfg_ld) begin
        latency_2x <= data[7:0]; latency_1x <= data[15:8]; mem_or_reg <= data[16];
      end
      if (state == REPLY_LOAD) begin tx_word <= rply; tx_cnt <= '0; end
      if (tx_fire) tx_data <= tx_word[DATA_W-1 -: 8];
      if (tx_shift) begin tx_word <= tx_word << 8; tx_cnt <= tx_cnt + BCW'(1); end
    end
  end

endmodule
